avg_pool3d_window_sequencer: RTL and testbench
==============================================

Name: avg_pool3d_window_sequencer

Overview:
- Control block for the 3D average-pooling datapath.
- Walks the input volume one pooling window at a time. Issues one read address per kernel element, tagged first/last so the downstream accumulator can clear, accumulate and divide.
- After each window it issues one output write address.
- Sits between the pooling-layer start/done control and the input-buffer read port / accumulator / output-buffer write port.

Parameters:
- D, 4, input depth.
- H, 4, input height.
- W, 4, input width.
- K, 2, cubic kernel size.
- S, 2, stride, applied identically on all axes. No padding.
- AW, 16, read/write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a pooling pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output address is accepted.
- rd_valid  out  1  read request valid.
- rd_ready  in  1  input buffer accepts the request.
- rd_addr  out  AW  linear input address, (d*H+h)*W+w.
- rd_first  out  1  marks the first element of a window; accumulator clears.
- rd_last  out  1  marks the last (K^3-th) element of a window.
- wr_valid  out  1  output write-address valid.
- wr_ready  in  1  output buffer accepts.
- wr_addr  out  AW  linear output address, (od*OH+oh)*OW+ow.

Behaviour:
- Derived constants:
  - OD=(D-K)/S+1, OH=(H-K)/S+1, OW=(W-K)/S+1, integer division.
  - Elaboration-time check: K<=D,H,W and S>=1.
- Reset (asynchronous, active-high): state IDLE; all counters 0; busy, done, rd_valid, rd_first, rd_last and wr_valid all 0; rd_addr and wr_addr 0.
- State machine (IDLE, READ, WRITE, FINISH):
  - IDLE: start=1 -> READ next cycle, busy=1. start in any other state is ignored.
  - READ: rd_valid=1, with rd_addr computed from the current window and kernel counters.
    - Kernel loop order is kd outermost, then kh, kw innermost.
    - Counters advance only on rd_valid&rd_ready.
    - rd_first=1 when kd=kh=kw=0. rd_last=1 when kd=kh=kw=K-1.
    - Handshake on the rd_last element -> WRITE. Kernel counters reset to 0 in the same cycle.
  - WRITE: rd_valid=0, wr_valid=1, wr_addr = current output index.
    - On wr_valid&wr_ready, window counters advance (ow innermost, then oh, then od).
    - Last window (od=OD-1, oh=OH-1, ow=OW-1) -> FINISH; otherwise -> READ.
  - FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, -> IDLE. All counters are 0 on return to IDLE.
- Handshake rules:
  - rd_valid, rd_addr, rd_first and rd_last hold stable while rd_valid=1 and rd_ready=0.
  - wr_valid and wr_addr hold stable while wr_valid=1 and wr_ready=0.
  - rd_valid and wr_valid are never high in the same cycle.
  - Back-to-back reads: one accepted per cycle when rd_ready stays high.
- Throughput with no backpressure: K^3 read cycles + 1 write cycle per window. Total busy time = OD*OH*OW*(K^3+1) cycles + 1 FINISH cycle.
- Arithmetic:
  - Addresses are built from registered counters as base + kernel offset.
  - Width AW is sized by the user to hold D*H*W-1; no wrap-around handling inside the block.
  - Addresses are registered outputs, with no combinational path from rd_ready or wr_ready.
- Reset mid-operation: returns to IDLE immediately, with no done pulse. Any partial window is discarded; downstream clears on the next rd_first.
- Degenerate case K=D=H=W (single window): one READ burst, one WRITE, then FINISH.

Test Plan:
- Defaults (4,4,4,2,2), rd_ready=wr_ready=1, pulse start:
  - Reads: first window 0,1,4,5,16,17,20,21, with rd_first on 0 and rd_last on 21.
  - Then wr_addr=0. Second window 2,3,6,7,18,19,22,23, then wr_addr=1.
  - 64 reads and 8 writes (wr_addr 0..7) in total; done exactly at cycle 73 after start.
- rd_ready low for 3 cycles in the middle of a window -> rd_addr, rd_first and rd_last are frozen; the address sequence is unchanged and completion is delayed by exactly 3 cycles.
- wr_ready held low for 5 cycles on window 3 -> wr_addr=3 held, no rd_valid asserted; reading resumes at window 4 base address 32.
- start re-pulsed while busy at window 2 -> ignored; exactly 8 writes and a single done pulse.
- Assert rst during window 5 READ -> next cycle rd_valid=0 and busy=0, with no done. A new start replays from rd_addr 0.
- D=H=W=3, K=3, S=1 -> 27 reads 0..26, rd_last on 26, one write with wr_addr=0, then done.

Source files
------------

// File: rtl/avg_pool3d_window_sequencer.sv
// Control FSM for 3D average pooling: walks each pooling window, issuing one read per
// kernel element (tagged first/last), then one output write address per window.
module avg_pool3d_window_sequencer #(
  parameter int unsigned D  = 4,
  parameter int unsigned H  = 4,
  parameter int unsigned W  = 4,
  parameter int unsigned K  = 2,
  parameter int unsigned S  = 2,
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic          rd_first,
  output logic          rd_last,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr
);

  localparam int unsigned OD  = (D - K) / S + 1;
  localparam int unsigned OH  = (H - K) / S + 1;
  localparam int unsigned OW  = (W - K) / S + 1;
  localparam int unsigned KCW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned DCW = (OD > 1) ? $clog2(OD) : 1;
  localparam int unsigned HCW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned WCW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [KCW-1:0] KMax  = KCW'(K - 1);
  localparam logic [DCW-1:0] OdMax = DCW'(OD - 1);
  localparam logic [HCW-1:0] OhMax = HCW'(OH - 1);
  localparam logic [WCW-1:0] OwMax = WCW'(OW - 1);

  localparam logic [AW-1:0] HA  = AW'(H);
  localparam logic [AW-1:0] WA  = AW'(W);
  localparam logic [AW-1:0] SA  = AW'(S);
  localparam logic [AW-1:0] OHA = AW'(OH);
  localparam logic [AW-1:0] OWA = AW'(OW);

  if (K > D || K > H || K > W || S < 1) begin : g_param_check
    $error("avg_pool3d_window_sequencer: kernel must fit the volume and stride must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFinish} state_e;

  state_e         state_q, state_d;
  logic [KCW-1:0] kd_q, kd_d, kh_q, kh_d, kw_q, kw_d;
  logic [DCW-1:0] od_q, od_d;
  logic [HCW-1:0] oh_q, oh_d;
  logic [WCW-1:0] ow_q, ow_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  always_comb begin
    state_d = state_q;
    kd_d    = kd_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    od_d    = od_q;
    oh_d    = oh_q;
    ow_d    = ow_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRead;
      end
      StRead: begin
        if (rd_ready) begin
          if (kw_q != KMax) begin
            kw_d = kw_q + 1'b1;
          end else begin
            kw_d = '0;
            if (kh_q != KMax) begin
              kh_d = kh_q + 1'b1;
            end else begin
              kh_d = '0;
              if (kd_q != KMax) begin
                kd_d = kd_q + 1'b1;
              end else begin
                kd_d    = '0;
                state_d = StWrite;
              end
            end
          end
        end
      end
      StWrite: begin
        if (wr_ready) begin
          state_d = StRead;
          if (ow_q != OwMax) begin
            ow_d = ow_q + 1'b1;
          end else begin
            ow_d = '0;
            if (oh_q != OhMax) begin
              oh_d = oh_q + 1'b1;
            end else begin
              oh_d = '0;
              if (od_q != OdMax) begin
                od_d = od_q + 1'b1;
              end else begin
                // Every window counter wraps to 0 here, so IDLE is re-entered clean.
                od_d    = '0;
                state_d = StFinish;
              end
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Addresses are precomputed from next-state counters so the outputs are pure flops.
    rd_addr_d = ((AW'(od_d) * SA + AW'(kd_d)) * HA + AW'(oh_d) * SA + AW'(kh_d)) * WA
              + AW'(ow_d) * SA + AW'(kw_d);
    wr_addr_d = (AW'(od_d) * OHA + AW'(oh_d)) * OWA + AW'(ow_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      kd_q      <= '0;
      kh_q      <= '0;
      kw_q      <= '0;
      od_q      <= '0;
      oh_q      <= '0;
      ow_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      kd_q      <= kd_d;
      kh_q      <= kh_d;
      kw_q      <= kw_d;
      od_q      <= od_d;
      oh_q      <= oh_d;
      ow_q      <= ow_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_valid = (state_q == StRead);
  assign wr_valid = (state_q == StWrite);
  assign busy     = rd_valid | wr_valid;
  assign done     = (state_q == StFinish);
  assign rd_first = rd_valid && (kd_q == '0) && (kh_q == '0) && (kw_q == '0);
  assign rd_last  = rd_valid && (kd_q == KMax) && (kh_q == KMax) && (kw_q == KMax);
  assign rd_addr  = rd_addr_q;
  assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_avg_pool3d_window_sequencer.sv
// Directed bench for the 3D average-pool window sequencer: default 4x4x4/K2/S2 instance
// plus a single-window 3x3x3/K3/S1 instance.
module tb_avg_pool3d_window_sequencer;

  logic        clk, rst, start, start3, rd_ready, wr_ready;
  logic        busy, done, rd_valid, rd_first, rd_last, wr_valid;
  logic [15:0] rd_addr, wr_addr;
  logic        busy3, done3, rd_valid3, rd_first3, rd_last3, wr_valid3;
  logic [15:0] rd_addr3, wr_addr3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int st_cyc, st_cyc3, done_cyc, done_cyc3;
  int done_cnt = 0, done_cnt3 = 0, both_cnt = 0;
  int rdq[$], fq[$], lq[$], wq[$];
  int rdq3[$], lq3[$], fq3[$], wq3[$];
  int exp_rd[64];
  int win01[16];

  avg_pool3d_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_first(rd_first), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr)
  );

  avg_pool3d_window_sequencer #(.D(3), .H(3), .W(3), .K(3), .S(1), .AW(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .rd_valid(rd_valid3), .rd_ready(rd_ready), .rd_addr(rd_addr3),
    .rd_first(rd_first3), .rd_last(rd_last3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready), .wr_addr(wr_addr3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are stable across the low phase; handshakes seen here complete at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        rdq.push_back(int'(rd_addr));
        fq.push_back(int'(rd_first));
        lq.push_back(int'(rd_last));
      end
      if (wr_valid && wr_ready) wq.push_back(int'(wr_addr));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_valid && wr_valid) both_cnt++;
      if (rd_valid3 && rd_ready) begin
        rdq3.push_back(int'(rd_addr3));
        fq3.push_back(int'(rd_first3));
        lq3.push_back(int'(rd_last3));
      end
      if (wr_valid3 && wr_ready) wq3.push_back(int'(wr_addr3));
      if (done3) begin
        done_cnt3++;
        done_cyc3 = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rdq.delete(); fq.delete(); lq.delete(); wq.delete();
    both_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input bit record);
    @(posedge clk); #1;
    start = 1'b1;
    if (record) st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= target) break;
    end
    if (i == 400) check_eq({tag, " done timeout"}, done_cnt, target);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input string tag, input bit writes, input int n);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ((writes ? wq.size() : rdq.size()) >= n) break;
    end
    if (i == 400) check_eq({tag, " wait timeout"}, writes ? wq.size() : rdq.size(), n);
  endtask

  task automatic verify_default(input string tag, input int exp_delta);
    check_eq({tag, " read count"}, rdq.size(), 64);
    for (int i = 0; i < rdq.size() && i < 64; i++) begin
      check_eq($sformatf("%s rd_addr[%0d]", tag, i), rdq[i], exp_rd[i]);
      check_eq($sformatf("%s rd_first[%0d]", tag, i), fq[i], int'(i % 8 == 0));
      check_eq($sformatf("%s rd_last[%0d]", tag, i), lq[i], int'(i % 8 == 7));
    end
    check_eq({tag, " write count"}, wq.size(), 8);
    for (int i = 0; i < wq.size() && i < 8; i++)
      check_eq($sformatf("%s wr_addr[%0d]", tag, i), wq[i], i);
    check_eq({tag, " done pulses"}, done_cnt, 1);
    check_eq({tag, " done latency"}, done_cyc - st_cyc, exp_delta);
    check_eq({tag, " rd/wr overlap"}, both_cnt, 0);
  endtask

  initial begin
    int n;
    win01 = '{0, 1, 4, 5, 16, 17, 20, 21, 2, 3, 6, 7, 18, 19, 22, 23};
    n = 0;
    for (int od = 0; od < 2; od++)
      for (int oh = 0; oh < 2; oh++)
        for (int ow = 0; ow < 2; ow++)
          for (int kd = 0; kd < 2; kd++)
            for (int kh = 0; kh < 2; kh++)
              for (int kw = 0; kw < 2; kw++) begin
                exp_rd[n] = ((od * 2 + kd) * 4 + oh * 2 + kh) * 4 + ow * 2 + kw;
                n++;
              end

    rst = 1'b1; start = 1'b0; start3 = 1'b0; rd_ready = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset rd_valid", int'(rd_valid), 0);
    check_eq("reset wr_valid", int'(wr_valid), 0);
    check_eq("reset rd_first", int'(rd_first), 0);
    check_eq("reset rd_last", int'(rd_last), 0);
    check_eq("reset rd_addr", int'(rd_addr), 0);
    check_eq("reset wr_addr", int'(wr_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Free-running pass.
    clear_logs();
    pulse_start(1'b1);
    check_eq("busy after start", int'(busy), 1);
    wait_done("base", 1);
    for (int i = 0; i < 16 && i < rdq.size(); i++)
      check_eq($sformatf("base window0/1 addr[%0d]", i), rdq[i], win01[i]);
    verify_default("base", 73);
    check_eq("busy after done", int'(busy), 0);

    // Read backpressure: 3 stalled cycles on the 4th element (address 5).
    clear_logs();
    pulse_start(1'b1);
    wait_count("rdstall", 1'b0, 3);
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rdstall rd_valid", int'(rd_valid), 1);
      check_eq("rdstall rd_addr", int'(rd_addr), 5);
      check_eq("rdstall rd_first", int'(rd_first), 0);
      check_eq("rdstall rd_last", int'(rd_last), 0);
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    wait_done("rdstall", 1);
    verify_default("rdstall", 76);

    // Write backpressure: 5 stalled cycles on window 3.
    clear_logs();
    pulse_start(1'b1);
    wait_count("wrstall", 1'b1, 3);
    wr_ready = 1'b0;
    n = 0;
    while (!wr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("wrstall wr_valid", int'(wr_valid), 1);
      check_eq("wrstall wr_addr", int'(wr_addr), 3);
      check_eq("wrstall rd_valid", int'(rd_valid), 0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    wait_done("wrstall", 1);
    if (rdq.size() > 32) check_eq("wrstall window4 base", rdq[32], 32);
    verify_default("wrstall", 78);

    // Start re-pulsed during window 2 must be ignored.
    clear_logs();
    pulse_start(1'b1);
    wait_count("restart", 1'b1, 2);
    pulse_start(1'b0);
    wait_done("restart", 1);
    repeat (10) @(posedge clk);
    #1;
    verify_default("restart", 73);

    // Reset in the middle of window 5's reads.
    clear_logs();
    pulse_start(1'b1);
    wait_count("midrst", 1'b1, 5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst rd_valid", int'(rd_valid), 0);
    check_eq("midrst busy", int'(busy), 0);
    check_eq("midrst rd_addr", int'(rd_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("midrst no done", done_cnt, 0);
    clear_logs();
    pulse_start(1'b1);
    wait_done("replay", 1);
    if (rdq.size() > 0) check_eq("replay first addr", rdq[0], 0);
    verify_default("replay", 73);

    // Single-window instance: 27 reads, one write.
    @(posedge clk); #1;
    start3 = 1'b1;
    st_cyc3 = cyc;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    while (done_cnt3 == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("k3 done pulses", done_cnt3, 1);
    check_eq("k3 read count", rdq3.size(), 27);
    for (int i = 0; i < rdq3.size() && i < 27; i++) begin
      check_eq($sformatf("k3 rd_addr[%0d]", i), rdq3[i], i);
      check_eq($sformatf("k3 rd_first[%0d]", i), fq3[i], int'(i == 0));
      check_eq($sformatf("k3 rd_last[%0d]", i), lq3[i], int'(i == 26));
    end
    check_eq("k3 write count", wq3.size(), 1);
    if (wq3.size() > 0) check_eq("k3 wr_addr", wq3[0], 0);
    check_eq("k3 done latency", done_cyc3 - st_cyc3, 29);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
